mon_sopc_led_ctrl: RTL

MON_SOPC_LED_CTRL -- requirements
Module: mon_sopc_led_ctrl

---
 rtl/mon_sopc_led_ctrl_pkg.sv | 9 +
 rtl/mon_sopc_blink_prescaler.sv | 30 +++
 rtl/mon_sopc_led_ctrl.sv | 62 ++++++
 3 files changed

// File: rtl/mon_sopc_led_ctrl_pkg.sv
// mon_sopc_led_ctrl_pkg: register map shared by the LED controller and its users
package mon_sopc_led_ctrl_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUTSET   = 3'd1;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd2;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd3;
  localparam logic [2:0] ADDR_PERIOD   = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
endpackage

// File: rtl/mon_sopc_blink_prescaler.sv
// mon_sopc_blink_prescaler: reloadable down-counter producing a square-wave blink phase
module mon_sopc_blink_prescaler #(
  parameter int PRESC_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PRESC_W-1:0] period,
  input  logic               load,
  output logic               phase
);
  logic [PRESC_W-1:0] cnt;
  // load wins over terminal count; a zero period parks the phase high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (load) begin
      cnt   <= period;
      phase <= 1'b1;
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == '0) begin
      cnt   <= period;
      phase <= ~phase;
    end else begin
      cnt   <= cnt - PRESC_W'(1);
    end
  end
endmodule

// File: rtl/mon_sopc_led_ctrl.sv
// mon_sopc_led_ctrl: Avalon-MM LED port with set/clear aliases and per-bit blinking
module mon_sopc_led_ctrl
  import mon_sopc_led_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               PRESC_W     = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0]   data;
  logic [WIDTH-1:0]   blink_en;
  logic [PRESC_W-1:0] period;
  logic               phase;
  logic               we;
  logic               load;
  logic [WIDTH-1:0]   wd_w;
  logic [PRESC_W-1:0] wd_p;
  logic               unused_wd;
  assign we        = chipselect & ~write_n;
  assign load      = we && address == ADDR_PERIOD;
  assign wd_w      = writedata[WIDTH-1:0];
  assign wd_p      = writedata[PRESC_W-1:0];
  assign unused_wd = ^writedata;
  // register file; reset beats any coincident write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data     <= RESET_VALUE;
      blink_en <= '0;
      period   <= '0;
    end else if (we) begin
      if (address == ADDR_DATA) data <= wd_w;
      else if (address == ADDR_OUTSET) data <= data | wd_w;
      else if (address == ADDR_OUTCLEAR) data <= data & ~wd_w;
      else if (address == ADDR_BLINK_EN) blink_en <= wd_w;
      else if (address == ADDR_PERIOD) period <= wd_p;
    end
  end
  // the prescaler sees the incoming period on the write edge so it reloads with the new value
  mon_sopc_blink_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (load ? wd_p : period),
    .load    (load),
    .phase   (phase)
  );
  // zero-wait read mux, independent of chipselect
  always_comb begin
    readdata = address == ADDR_DATA     ? 32'(data)     :
               address == ADDR_BLINK_EN ? 32'(blink_en) :
               address == ADDR_PERIOD   ? 32'(period)   :
               address == ADDR_STATUS   ? 32'(phase)    : 32'd0;
  end
  assign out_port = data & (~blink_en | {WIDTH{phase}});
endmodule
